// File: rtl/load_align.sv
// Load alignment unit: captures a load request, waits for the load unit,
// lane-selects and extends the returned word, then holds a write-back
// request until the register file accepts it.
// Optional feature: define LOAD_TIMEOUT_EN to fault a load whose response
// never arrives within TIMEOUT WAIT cycles.
module load_align #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_issue,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [1:0]  i_addr_lo,
  input  logic [3:0]  i_rd,
  input  logic [31:0] i_data,
  input  logic        i_valid,
  input  logic        i_error,
  output logic        o_busy,
  output logic [3:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_wb_en,
  input  logic        i_wb_ready,
  output logic        o_fault
);

  // state | meaning
  // IDLE  | no load in flight, accepts a new issue
  // WAIT  | request captured, waiting for load-unit data or error
  // WB    | aligned result held on the write-back port until accepted
  typedef enum logic [1:0] {IDLE, WAIT, WB} state_t;

  generate
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("load_align: TIMEOUT must be in 1..255");
    end
  endgenerate

  state_t      state, state_nx;
  logic [1:0]  size_q, size_nx;
  logic        signed_q, signed_nx;
  logic [1:0]  addr_q, addr_nx;
  logic [3:0]  rd_q, rd_nx;
  logic [3:0]  wb_rd_nx;
  logic [31:0] wb_data_nx;
  logic        wb_en_nx;
  logic        fault_nx;
  logic [31:0] aligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
`ifdef LOAD_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_nx;
`endif

  assign o_busy = (state != IDLE);

  // Big-endian lane selection and sign/zero extension of the raw word.
  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    aligned  = i_data;
    case (addr_q)
      2'b00:   byte_sel = i_data[31:24];
      2'b01:   byte_sel = i_data[23:16];
      2'b10:   byte_sel = i_data[15:8];
      default: byte_sel = i_data[7:0];
    endcase
    half_sel = addr_q[1] ? i_data[15:0] : i_data[31:16];
    case (size_q)
      2'b01:   aligned = signed_q ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
      2'b10:   aligned = signed_q ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
      default: aligned = i_data;
    endcase
  end

  // Next-state and next-output decode; everything holds unless a branch says otherwise.
  always_comb begin
    state_nx   = state;
    size_nx    = size_q;
    signed_nx  = signed_q;
    addr_nx    = addr_q;
    rd_nx      = rd_q;
    wb_rd_nx   = o_wb_rd;
    wb_data_nx = o_wb_data;
    wb_en_nx   = o_wb_en;
    fault_nx   = 1'b0;
`ifdef LOAD_TIMEOUT_EN
    cnt_nx     = cnt_q;
`endif
    case (state)
      IDLE: begin
        if (i_issue && i_size != 2'b00) begin
          size_nx   = i_size;
          signed_nx = i_signed;
          addr_nx   = i_addr_lo;
          rd_nx     = i_rd;
          state_nx  = WAIT;
`ifdef LOAD_TIMEOUT_EN
          cnt_nx    = 8'h00;
`endif
        end
      end
      WAIT: begin
        if (i_error) begin
          fault_nx = 1'b1;
          state_nx = IDLE;
        end else if (i_valid) begin
          wb_data_nx = aligned;
          wb_rd_nx   = rd_q;
          wb_en_nx   = 1'b1;
          state_nx   = WB;
        end
`ifdef LOAD_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT - 1)) begin
          fault_nx = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt_q + 8'd1;
        end
`endif
      end
      WB: begin
        if (i_wb_ready) begin
          wb_en_nx = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers; reset discards any in-flight load.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      size_q    <= 2'b00;
      signed_q  <= 1'b0;
      addr_q    <= 2'b00;
      rd_q      <= 4'h0;
      o_wb_rd   <= 4'h0;
      o_wb_data <= 32'h0;
      o_wb_en   <= 1'b0;
      o_fault   <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
      cnt_q     <= 8'h00;
`endif
    end else begin
      state     <= state_nx;
      size_q    <= size_nx;
      signed_q  <= signed_nx;
      addr_q    <= addr_nx;
      rd_q      <= rd_nx;
      o_wb_rd   <= wb_rd_nx;
      o_wb_data <= wb_data_nx;
      o_wb_en   <= wb_en_nx;
      o_fault   <= fault_nx;
`ifdef LOAD_TIMEOUT_EN
      cnt_q     <= cnt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_load_align.sv
// Directed bench for load_align: reset, lane/extension table, back-pressure,
// error, ignored issues, reset during write-back and the optional timeout.
module tb_load_align;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue, sgn, valid, err, wb_ready;
  logic [1:0]  size, addr_lo;
  logic [3:0]  rd;
  logic [31:0] data;
  logic        busy, wb_en, fault;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  load_align #(.TIMEOUT(4)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_issue(issue), .i_size(size),
    .i_signed(sgn), .i_addr_lo(addr_lo), .i_rd(rd), .i_data(data),
    .i_valid(valid), .i_error(err), .o_busy(busy), .o_wb_rd(wb_rd),
    .o_wb_data(wb_data), .o_wb_en(wb_en), .i_wb_ready(wb_ready),
    .o_fault(fault)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue = 0; size = 2'b00; sgn = 0; addr_lo = 2'b00; rd = 4'h0;
    data = 32'h0; valid = 0; err = 0; wb_ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #12;
    total++;
    if ({busy, wb_en, fault, wb_rd, wb_data} !== 39'h0)
      $display("FAIL reset_outputs: got busy=%b en=%b fault=%b rd=%h data=%h, want all 0",
               busy, wb_en, fault, wb_rd, wb_data);
    else passed++;
    @(negedge clk);
    rst_n = 1;
    valid = 1; err = 1;
    step();
    valid = 0; err = 0;
    total++;
    if (busy !== 0 || fault !== 0 || wb_en !== 0)
      $display("FAIL stale_idle: busy=%b fault=%b en=%b, want 0 0 0", busy, fault, wb_en);
    else passed++;
  endtask

  task automatic test_signed_byte();
    issue = 1; size = 2'b01; sgn = 1; addr_lo = 2'b10; rd = 4'd5;
    step();
    issue = 0;
    total++;
    if (busy !== 1) $display("FAIL sb_busy: got %b want 1", busy); else passed++;
    data = 32'h1234_8077; valid = 1;
    step();
    valid = 0;
    total++;
    if (wb_en !== 1 || wb_data !== 32'hFFFF_FF80 || wb_rd !== 4'd5)
      $display("FAIL sb_result: en=%b data=%h rd=%0d, want 1 ffffff80 5", wb_en, wb_data, wb_rd);
    else passed++;
    wb_ready = 1;
    step();
    wb_ready = 0;
    total++;
    if (wb_en !== 0 || busy !== 0)
      $display("FAIL sb_done: en=%b busy=%b, want 0 0", wb_en, busy);
    else passed++;
  endtask

  task automatic test_half_backpressure();
    issue = 1; size = 2'b10; sgn = 0; addr_lo = 2'b00; rd = 4'd7;
    step();
    issue = 0;
    wb_ready = 1;  // ready while no write-back pending must be harmless
    step();
    wb_ready = 0;
    data = 32'hBEEF_0001; valid = 1;
    step();
    valid = 0; data = 32'h0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (wb_en !== 1 || wb_data !== 32'h0000_BEEF || wb_rd !== 4'd7 || busy !== 1)
        $display("FAIL half_hold%0d: en=%b data=%h rd=%0d busy=%b, want 1 0000beef 7 1",
                 i, wb_en, wb_data, wb_rd, busy);
      else passed++;
      step();
    end
    total++;
    if (wb_en !== 1) $display("FAIL half_hold3: en=%b want 1", wb_en); else passed++;
    wb_ready = 1;
    step();
    wb_ready = 0;
    total++;
    if (wb_en !== 0 || busy !== 0)
      $display("FAIL half_release: en=%b busy=%b, want 0 0", wb_en, busy);
    else passed++;
  endtask

  task automatic test_lanes();
    logic [1:0]  t_size [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                                 2'b10, 2'b10, 2'b10, 2'b11};
    logic        t_sgn  [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 0, 1};
    logic [1:0]  t_addr [10] = '{2'b00, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11,
                                 2'b01, 2'b11, 2'b10, 2'b10};
    logic [31:0] t_exp  [10] = '{32'h0000_0080, 32'h0000_007F, 32'hFFFF_FF80,
                                 32'hFFFF_FFC1, 32'hFFFF_FFA2, 32'h0000_007F,
                                 32'hFFFF_80C1, 32'hFFFF_A27F, 32'h0000_A27F,
                                 32'h80C1_A27F};
    for (int i = 0; i < 10; i++) begin
      issue = 1; size = t_size[i]; sgn = t_sgn[i]; addr_lo = t_addr[i]; rd = 4'(i);
      step();
      issue = 0;
      data = 32'h80C1_A27F; valid = 1;
      step();
      valid = 0; wb_ready = 1;
      total++;
      if (wb_en !== 1 || wb_data !== t_exp[i] || wb_rd !== 4'(i))
        $display("FAIL lane%0d: en=%b data=%h rd=%0d, want 1 %h %0d",
                 i, wb_en, wb_data, wb_rd, t_exp[i], i);
      else passed++;
      step();
      wb_ready = 0;
    end
  endtask

  task automatic test_error();
    issue = 1; size = 2'b11; rd = 4'd2;
    step();
    issue = 0;
    valid = 1; err = 1; data = 32'h1111_1111;
    step();
    valid = 0; err = 0;
    total++;
    if (fault !== 1 || wb_en !== 0 || busy !== 0)
      $display("FAIL err_pulse: fault=%b en=%b busy=%b, want 1 0 0", fault, wb_en, busy);
    else passed++;
    step();
    total++;
    if (fault !== 0 || wb_en !== 0)
      $display("FAIL err_once: fault=%b en=%b, want 0 0", fault, wb_en);
    else passed++;
  endtask

  task automatic test_ignored_issue();
    issue = 1; size = 2'b00; rd = 4'd9;
    step();
    issue = 0;
    total++;
    if (busy !== 0) $display("FAIL size0_ignored: busy=%b want 0", busy); else passed++;
    issue = 1; size = 2'b11; sgn = 0; addr_lo = 2'b00; rd = 4'd3;
    step();
    issue = 1; size = 2'b01; sgn = 1; addr_lo = 2'b11; rd = 4'd9;
    step();
    issue = 0;
    total++;
    if (busy !== 1 || wb_en !== 0)
      $display("FAIL wait_issue: busy=%b en=%b, want 1 0", busy, wb_en);
    else passed++;
    data = 32'hDEAD_BEEF; valid = 1;
    step();
    valid = 0;
    total++;
    if (wb_en !== 1 || wb_data !== 32'hDEAD_BEEF || wb_rd !== 4'd3)
      $display("FAIL word_kept: en=%b data=%h rd=%0d, want 1 deadbeef 3", wb_en, wb_data, wb_rd);
    else passed++;
    wb_ready = 1;
    step();
    wb_ready = 0;
  endtask

  task automatic test_reset_in_wb();
    issue = 1; size = 2'b11; rd = 4'd4;
    step();
    issue = 0;
    data = 32'hCAFE_F00D; valid = 1;
    step();
    valid = 0;
    #2;
    rst_n = 0;
    #1;
    total++;
    if (wb_en !== 0 || busy !== 0 || wb_data !== 32'h0)
      $display("FAIL reset_wb: en=%b busy=%b data=%h, want 0 0 0", wb_en, busy, wb_data);
    else passed++;
    #3;
    rst_n = 1;
    valid = 1;
    step();
    step();
    valid = 0;
    total++;
    if (wb_en !== 0 || busy !== 0)
      $display("FAIL stray_valid: en=%b busy=%b, want 0 0", wb_en, busy);
    else passed++;
  endtask

  task automatic test_timeout();
    issue = 1; size = 2'b11; rd = 4'd1;
    step();
    issue = 0;
`ifdef LOAD_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (fault !== 0 || busy !== 1)
        $display("FAIL to_early%0d: fault=%b busy=%b, want 0 1", i, fault, busy);
      else passed++;
    end
    step();
    total++;
    if (fault !== 1 || busy !== 0)
      $display("FAIL to_fire: fault=%b busy=%b, want 1 0", fault, busy);
    else passed++;
    step();
    total++;
    if (fault !== 0) $display("FAIL to_once: fault=%b want 0", fault); else passed++;
`else
    begin
      int drops = 0;
      for (int i = 0; i < 300; i++) begin
        step();
        if (busy !== 1 || fault !== 0) drops++;
      end
      total++;
      if (drops != 0)
        $display("FAIL no_timeout: %0d cycles not busy or faulted, want 0", drops);
      else passed++;
    end
    rst_n = 0;
    #4;
    rst_n = 1;
    step();
`endif
  endtask

  initial begin
    test_reset();
    test_signed_byte();
    test_half_backpressure();
    test_lanes();
    test_error();
    test_ignored_issue();
    test_reset_in_wb();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/load_align.md
LOAD_ALIGN -- requirements
Module: load_align

Interface
REQ-001 Parameter TIMEOUT, default 255, number of WAIT cycles before a missing response is faulted; range 1..255; used only with LOAD_TIMEOUT_EN.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 i_reset  in  1  asynchronous, active-low reset.
REQ-005 i_issue  in  1  CPU starts a load this cycle.
REQ-006 i_size  in  2  access size: 01 = byte, 10 = half, 11 = word, 00 = invalid.
REQ-007 i_signed  in  1  sign-extend (1) or zero-extend (0) the byte or half result.
REQ-008 i_addr_lo  in  2  load address bits [1:0].
REQ-009 i_rd  in  4  destination register index.
REQ-010 i_data  in  32  raw word from the load unit.
REQ-011 i_valid  in  1  load unit data-valid pulse.
REQ-012 i_error  in  1  load unit bus-error flag.
REQ-013 o_busy  out  1  a load is in flight; new issues are ignored.
REQ-014 o_wb_rd  out  4  write-back register index.
REQ-015 o_wb_data  out  32  aligned and extended result.
REQ-016 o_wb_en  out  1  write-back request.
REQ-017 i_wb_ready  in  1  register file accepts the write-back.
REQ-018 o_fault  out  1  one-cycle pulse: load failed, no write-back.

Function
REQ-019 FSM states are IDLE, WAIT and WB; o_busy SHALL be 1 exactly when the state is not IDLE.
REQ-020 IDLE: when i_issue=1 and i_size!=00, capture size, signed, addr_lo and rd, then go to WAIT.
REQ-021 IDLE: i_issue with i_size=00 is ignored; i_valid and i_error are ignored (stale responses).
REQ-022 WAIT/WB: i_issue is ignored, and captured fields do not change.
REQ-023 Byte lane selection (big-endian): addr_lo 00 selects bits 31:24, 01 selects 23:16, 10 selects 15:8, 11 selects 7:0.
REQ-024 Half lane selection: addr_lo[1]=0 selects bits 31:16; addr_lo[1]=1 selects bits 15:0; addr_lo[0] is ignored.
REQ-025 Word: i_data passes unchanged; i_signed has no effect.
REQ-026 Extension: byte or half is zero- or sign-extended to 32 bits according to the captured signed flag.
REQ-027 WAIT, i_valid=1 and i_error=0: register the aligned result into o_wb_data, set o_wb_rd, assert o_wb_en on the next cycle and go to WB (latency 1 cycle).
REQ-028 WAIT, i_error=1: pulse o_fault for exactly 1 cycle on the next cycle and go to IDLE; error wins if i_valid is also 1.
REQ-029 WB: hold o_wb_en, o_wb_data and o_wb_rd stable until i_wb_ready=1 is sampled.
REQ-030 Handshake: o_wb_en deasserts on the cycle after i_wb_ready is sampled, and the FSM goes to IDLE.
REQ-031 WB: i_wb_ready=1 in the first cycle of WB completes in 1 cycle; i_wb_ready while o_wb_en=0 has no effect.
REQ-032 WB: i_valid and i_error are ignored.

Reset
REQ-033 Asserting i_reset (low) SHALL immediately force IDLE, o_busy=0, o_wb_en=0, o_fault=0, o_wb_data=0, o_wb_rd=0 and the timeout counter to 0.
REQ-034 Reset mid-operation discards the in-flight load; a later i_valid is ignored under REQ-021.
REQ-035 Deassertion may be asynchronous; the first i_issue is accepted on the first rising edge with i_reset high.

Configuration
REQ-036 Macro LOAD_TIMEOUT_EN compiles the timeout feature in or out.
REQ-037 Defined: an 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
REQ-038 Defined: when the counter reaches TIMEOUT with no i_valid or i_error, pulse o_fault for 1 cycle and go to IDLE.
REQ-039 Defined: i_valid or i_error in the same cycle the counter reaches TIMEOUT takes priority over the timeout.
REQ-040 Undefined: no counter exists; WAIT lasts indefinitely, and the Parameter TIMEOUT is unused.

Verification
REQ-041 Signed byte: issue size=01, signed=1, addr_lo=10, rd=5; i_data=0x1234_8077 -> o_wb_data=0xFFFF_FF80, o_wb_rd=5, o_wb_en high 1 cycle after i_valid.
REQ-042 Unsigned half: size=10, signed=0, addr_lo=00; i_data=0xBEEF_0001 -> o_wb_data=0x0000_BEEF; with i_wb_ready held low 3 cycles, output stays stable, then deasserts 1 cycle after ready.
REQ-043 Error path: issue, then i_valid=1 and i_error=1 together -> o_fault pulses 1 cycle, o_wb_en stays 0, o_busy=0 on the following cycle.
REQ-044 Ignored issue: second issue during WAIT, and issue with size=00 in IDLE -> no capture, state unchanged; word load 0xDEAD_BEEF still returns 0xDEAD_BEEF.
REQ-045 Reset: i_reset low during WB -> o_wb_en=0 and o_busy=0 immediately; a stray i_valid after release -> no write-back.
REQ-046 Timeout (LOAD_TIMEOUT_EN defined, TIMEOUT=4): issue with no response -> o_fault after 4 WAIT cycles; macro undefined -> o_busy stays 1 for 300 cycles.
